// File: rtl/snitch_pkg.sv
// Shared Snitch VFPR write-path types and constants.
// The write-request record and the default in-flight limit are used by snitch_vfpr_wr_arb.
package snitch_pkg;

  localparam int unsigned VfprAddrWidth      = 32;
  localparam int unsigned VfprDataWidth      = 64;
  localparam int unsigned VfprMaxOutstanding = 4;

  typedef struct packed {
    logic [VfprAddrWidth-1:0] addr;
    logic [VfprDataWidth-1:0] data;
  } vfpr_wr_req_t;

  // Modulo-n increment for circular pointers whose depth need not be a power of two
  function automatic logic [31:0] wrap_inc(input logic [31:0] v, input logic [31:0] n);
    logic [31:0] nxt;
    nxt = v + 32'd1;
    if (nxt >= n) begin
      return 32'd0;
    end else begin
      return nxt;
    end
  endfunction

endpackage

// File: rtl/rr_arb_tree.sv
// Round-robin arbiter: picks the first valid request at or after the priority pointer.
// The pointer moves past the winner only when the winner is actually taken (ready_i).
module rr_arb_tree
  import snitch_pkg::*;
#(
  parameter  int unsigned NumIn = 2,
  localparam int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIn-1:0] req_i,
  input  logic             ready_i,
  output logic [NumIn-1:0] gnt_o,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0] rr_q, rr_d;

  // Rotating priority search plus one-hot grant and pointer update
  always_comb begin
    logic [31:0] c;
    valid_o = 1'b0;
    idx_o   = '0;
    gnt_o   = '0;
    rr_d    = rr_q;
    for (int unsigned k = 0; k < NumIn; k++) begin
      c = (32'(rr_q) + k) % NumIn;
      if (!valid_o && req_i[IdxW'(c)]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(c);
      end else begin
        valid_o = valid_o;
      end
    end
    for (int unsigned k = 0; k < NumIn; k++) begin
      gnt_o[k] = valid_o & ready_i & (idx_o == IdxW'(k));
    end
    if (valid_o && ready_i) begin
      rr_d = IdxW'(wrap_inc(32'(idx_o), NumIn));
    end else begin
      rr_d = rr_q;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/snitch_vfpr_wr_arb.sv
// VFPR write arbiter: round-robin over requesters, one output stage, in-flight write
// counting and optional read-operand hazard check (SNITCH_VFPR_WR_ARB_HAZARD_EN).
module snitch_vfpr_wr_arb
  import snitch_pkg::*;
#(
  parameter  int unsigned NumReq         = 2,
  parameter  int unsigned AddrWidth      = VfprAddrWidth,
  parameter  int unsigned DataWidth      = VfprDataWidth,
  parameter  int unsigned MaxOutstanding = VfprMaxOutstanding,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0] req_data_i,
  output logic                            wr_q_valid_o,
  input  logic                            wr_q_ready_i,
  output logic [AddrWidth-1:0]            wr_q_addr_o,
  output logic [DataWidth-1:0]            wr_q_data_o,
  input  logic                            wr_p_valid_i,
  input  logic [2:0][AddrWidth-1:0]       chk_addr_i,
  output logic [2:0]                      chk_hit_o,
  output logic [CntW-1:0]                 outstanding_o,
  output logic                            err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic            arb_valid, arb_ready, accept, pop, stray_ack;
  logic [IdxW-1:0] arb_idx;
  logic            stage_valid_q, stage_valid_d;
  vfpr_wr_req_t    stage_q, stage_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // An ack in the same cycle frees a slot, so the limit can be hit without a bubble
  assign arb_ready = rst_ni
                   & ((cnt_q < CntW'(MaxOutstanding)) | wr_p_valid_i)
                   & (~stage_valid_q | wr_q_ready_i);
  assign accept    = arb_valid & arb_ready;
  assign pop       = wr_p_valid_i & (cnt_q != '0);
  assign stray_ack = wr_p_valid_i & (cnt_q == '0);

  rr_arb_tree #(.NumIn(NumReq)) i_rr_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_valid_i),
    .ready_i (arb_ready),
    .gnt_o   (req_ready_o),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  // Output stage, in-flight counter and sticky error next-state
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_d       = stage_q;
    cnt_d         = cnt_q;
    err_d         = err_q | stray_ack;
    if (accept) begin
      stage_valid_d = 1'b1;
      stage_d.addr  = VfprAddrWidth'(req_addr_i[arb_idx]);
      stage_d.data  = VfprDataWidth'(req_data_i[arb_idx]);
    end else if (wr_q_ready_i) begin
      stage_valid_d = 1'b0;
    end else begin
      stage_valid_d = stage_valid_q;
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_q       <= stage_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
    end
  end

  assign wr_q_valid_o  = stage_valid_q;
  assign wr_q_addr_o   = AddrWidth'(stage_q.addr);
  assign wr_q_data_o   = DataWidth'(stage_q.data);
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

`ifdef SNITCH_VFPR_WR_ARB_HAZARD_EN
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [AddrWidth-1:0]      fifo_addr_q [MaxOutstanding];
  logic [MaxOutstanding-1:0] fifo_vld_q, fifo_vld_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  // Pop before push so a full FIFO can retire and refill the same slot in one cycle
  always_comb begin
    fifo_vld_d = fifo_vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (pop) begin
      fifo_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = PtrW'(wrap_inc(32'(rd_ptr_q), MaxOutstanding));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (accept) begin
      fifo_vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d             = PtrW'(wrap_inc(32'(wr_ptr_q), MaxOutstanding));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Tracking FIFO registers; addresses are qualified by the valid bits
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fifo_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fifo_vld_q <= fifo_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (accept) begin
        fifo_addr_q[wr_ptr_q] <= req_addr_i[arb_idx];
      end else begin
        fifo_addr_q[wr_ptr_q] <= fifo_addr_q[wr_ptr_q];
      end
    end
  end

  // Operand hazard compare against every live entry, including the one retiring now
  always_comb begin
    chk_hit_o = 3'b000;
    for (int unsigned k = 0; k < 3; k++) begin
      for (int unsigned e = 0; e < MaxOutstanding; e++) begin
        if (fifo_vld_q[e] && (fifo_addr_q[e] == chk_addr_i[k])) begin
          chk_hit_o[k] = 1'b1;
        end else begin
          chk_hit_o[k] = chk_hit_o[k];
        end
      end
    end
  end
`else
  logic unused_chk_addr;
  assign unused_chk_addr = ^chk_addr_i;
  assign chk_hit_o       = 3'b000;
`endif

endmodule

// File: tb/tb_snitch_vfpr_wr_arb.sv
// Directed table-driven bench for snitch_vfpr_wr_arb (default parameters),
// plus hand-written error / reset sequences.
module tb_snitch_vfpr_wr_arb;

  localparam logic [31:0] A0 = 32'h0000_0080;
  localparam logic [63:0] D0 = 64'h0000_0000_0000_00A0;
  localparam logic [31:0] A1 = 32'h0000_0040;
  localparam logic [63:0] D1 = 64'h0000_0000_0000_DEAD;
`ifdef SNITCH_VFPR_WR_ARB_HAZARD_EN
  localparam logic [2:0] H = 3'b010;
`else
  localparam logic [2:0] H = 3'b000;
`endif

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [1:0]        req_valid_i, req_ready_o;
  logic [1:0][31:0]  req_addr_i;
  logic [1:0][63:0]  req_data_i;
  logic              wr_q_valid_o, wr_q_ready_i;
  logic [31:0]       wr_q_addr_o;
  logic [63:0]       wr_q_data_o;
  logic              wr_p_valid_i;
  logic [2:0][31:0]  chk_addr_i;
  logic [2:0]        chk_hit_o;
  logic [2:0]        outstanding_o;
  logic              err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  snitch_vfpr_wr_arb dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
    .wr_q_valid_o  (wr_q_valid_o),
    .wr_q_ready_i  (wr_q_ready_i),
    .wr_q_addr_o   (wr_q_addr_o),
    .wr_q_data_o   (wr_q_data_o),
    .wr_p_valid_i  (wr_p_valid_i),
    .chk_addr_i    (chk_addr_i),
    .chk_hit_o     (chk_hit_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  typedef struct {
    logic [1:0]  rv;
    logic        qr;
    logic        pv;
    logic [1:0]  rdy;
    logic [2:0]  hit;
    logic        vld;
    logic        pl;
    logic [31:0] addr;
    logic [63:0] data;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs driven just after an edge, combinational outputs checked before the next edge,
  // registered outputs checked 1 time unit after it.
  task automatic step(input int i);
    req_valid_i  = vecs[i].rv;
    wr_q_ready_i = vecs[i].qr;
    wr_p_valid_i = vecs[i].pv;
    #1;
    check($sformatf("v%0d_ready", i), 64'(req_ready_o), 64'(vecs[i].rdy));
    check($sformatf("v%0d_hit", i), 64'(chk_hit_o), 64'(vecs[i].hit));
    cyc();
    check($sformatf("v%0d_qvalid", i), 64'(wr_q_valid_o), 64'(vecs[i].vld));
    check($sformatf("v%0d_cnt", i), 64'(outstanding_o), 64'(vecs[i].cnt));
    check($sformatf("v%0d_err", i), 64'(err_o), 64'd0);
    if (vecs[i].pl) begin
      check($sformatf("v%0d_addr", i), 64'(wr_q_addr_o), 64'(vecs[i].addr));
      check($sformatf("v%0d_data", i), wr_q_data_o, vecs[i].data);
    end
  endtask

  initial begin
    //           rv     qr    pv    rdy    hit     vld   pl    addr data cnt
    // alternating grants, one ack per cycle
    vecs[0]  = '{2'b11, 1'b1, 1'b0, 2'b01, 3'b000, 1'b1, 1'b1, A0, D0, 3'd1};
    vecs[1]  = '{2'b11, 1'b1, 1'b1, 2'b10, H,      1'b1, 1'b1, A1, D1, 3'd1};
    vecs[2]  = '{2'b11, 1'b1, 1'b1, 2'b01, 3'b000, 1'b1, 1'b1, A0, D0, 3'd1};
    vecs[3]  = '{2'b11, 1'b1, 1'b1, 2'b10, H,      1'b1, 1'b1, A1, D1, 3'd1};
    vecs[4]  = '{2'b00, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, A0, D0, 3'd0};
    // fill to the limit, then an ack admits one more in the same cycle
    vecs[5]  = '{2'b01, 1'b1, 1'b0, 2'b01, 3'b000, 1'b1, 1'b1, A0, D0, 3'd1};
    vecs[6]  = '{2'b01, 1'b1, 1'b0, 2'b01, H,      1'b1, 1'b1, A0, D0, 3'd2};
    vecs[7]  = '{2'b01, 1'b1, 1'b0, 2'b01, H,      1'b1, 1'b1, A0, D0, 3'd3};
    vecs[8]  = '{2'b01, 1'b1, 1'b0, 2'b01, H,      1'b1, 1'b1, A0, D0, 3'd4};
    vecs[9]  = '{2'b01, 1'b1, 1'b0, 2'b00, H,      1'b0, 1'b0, A0, D0, 3'd4};
    vecs[10] = '{2'b01, 1'b1, 1'b0, 2'b00, H,      1'b0, 1'b0, A0, D0, 3'd4};
    vecs[11] = '{2'b01, 1'b1, 1'b1, 2'b01, H,      1'b1, 1'b1, A0, D0, 3'd4};
    vecs[12] = '{2'b00, 1'b1, 1'b1, 2'b00, H,      1'b0, 1'b0, A0, D0, 3'd3};
    vecs[13] = '{2'b00, 1'b1, 1'b1, 2'b00, H,      1'b0, 1'b0, A0, D0, 3'd2};
    vecs[14] = '{2'b00, 1'b1, 1'b1, 2'b00, H,      1'b0, 1'b0, A0, D0, 3'd1};
    vecs[15] = '{2'b00, 1'b1, 1'b1, 2'b00, H,      1'b0, 1'b0, A0, D0, 3'd0};
    // 0x40/0xDEAD held in the stage for 3 stalled cycles, issued on the 4th
    vecs[16] = '{2'b10, 1'b1, 1'b0, 2'b10, 3'b000, 1'b1, 1'b1, A1, D1, 3'd1};
    vecs[17] = '{2'b01, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1, A1, D1, 3'd1};
    vecs[18] = '{2'b01, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1, A1, D1, 3'd1};
    vecs[19] = '{2'b01, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1, A1, D1, 3'd1};
    vecs[20] = '{2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, A1, D1, 3'd1};
    vecs[21] = '{2'b00, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, A1, D1, 3'd0};

    rst_ni        = 1'b0;
    req_valid_i   = 2'b11;
    wr_q_ready_i  = 1'b0;
    wr_p_valid_i  = 1'b0;
    req_addr_i    = {A1, A0};
    req_data_i    = {D1, D0};
    chk_addr_i    = {32'h0000_0999, A0, 32'h0000_0777};
    #1;
    check("rst_ready_comb", 64'(req_ready_o), 64'd0);
    cyc();
    cyc();
    check("rst_qvalid", 64'(wr_q_valid_o), 64'd0);
    check("rst_cnt", 64'(outstanding_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_hit", 64'(chk_hit_o), 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'd0);
    rst_ni      = 1'b1;
    req_valid_i = 2'b00;

    for (int i = 0; i < 22; i++) begin
      step(i);
    end

    // Stray ack with nothing in flight: sticky error, counter stays 0
    wr_p_valid_i = 1'b1;
    cyc();
    check("err_set", 64'(err_o), 64'd1);
    check("err_cnt", 64'(outstanding_o), 64'd0);
    wr_p_valid_i = 1'b0;
    cyc();
    cyc();
    check("err_sticky", 64'(err_o), 64'd1);

    // Put a write in flight, then reset mid-operation
    req_valid_i  = 2'b01;
    wr_q_ready_i = 1'b1;
    cyc();
    check("pre_rst_qvalid", 64'(wr_q_valid_o), 64'd1);
    check("pre_rst_cnt", 64'(outstanding_o), 64'd1);
    check("pre_rst_hit", 64'(chk_hit_o), 64'(H));
    rst_ni       = 1'b0;
    req_valid_i  = 2'b11;
    wr_q_ready_i = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready_o), 64'd0);
    cyc();
    check("mid_rst_qvalid", 64'(wr_q_valid_o), 64'd0);
    check("mid_rst_cnt", 64'(outstanding_o), 64'd0);
    check("mid_rst_err", 64'(err_o), 64'd0);
    check("mid_rst_hit", 64'(chk_hit_o), 64'd0);

    // Pointer back at requester 0 after reset
    rst_ni = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready_o), 64'd1);
    req_valid_i = 2'b00;
    cyc();

    // Ack of the discarded write is a protocol error
    wr_p_valid_i = 1'b1;
    cyc();
    check("stale_ack_err", 64'(err_o), 64'd1);
    check("stale_ack_cnt", 64'(outstanding_o), 64'd0);
    wr_p_valid_i = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
